// File: rtl/dmem_arb_pkg.sv
// Shared types and address helpers for the data-memory line arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RCAP = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  localparam int LINE_OFFSET_BITS = 5;

  // Byte address of a line: the index sits directly above the 32-byte offset.
  function automatic logic [31:0] line_to_byte_addr(input logic [31:0] line_idx);
    return line_idx << LINE_OFFSET_BITS;
  endfunction

endpackage

// File: rtl/dmem_line_arbiter_if.sv
// Line-requester handshake bundle: master = requester side, slave = arbiter side.
interface dmem_line_arbiter_if #(
  parameter int LINE_WIDTH      = 256,
  parameter int LINE_ADDR_WIDTH = 7
);
  logic [1:0]                 req_valid;
  logic [1:0]                 req_write;
  logic [LINE_ADDR_WIDTH-1:0] req_line0;
  logic [LINE_ADDR_WIDTH-1:0] req_line1;
  logic [LINE_WIDTH-1:0]      req_wdata0;
  logic [LINE_WIDTH-1:0]      req_wdata1;
  logic [1:0]                 req_ready;
  logic [1:0]                 rsp_valid;
  logic [LINE_WIDTH-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_write, req_line0, req_line1, req_wdata0, req_wdata1,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_line0, req_line1, req_wdata0, req_wdata1,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dmem_line_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: on contention the requester that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);
  // NOTE: grant gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end
endmodule

// File: rtl/dmem_line_arbiter.sv
// Shares data_mem's line port between loader/DMA (req 0) and debug/trace (req 1); the CPU always wins.
// Define DMEM_ARB_STARVE_EN to add the starvation counter that raises cpu_hold.
module dmem_line_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int LINE_WIDTH      = 256,
  parameter int LINE_ADDR_WIDTH = 7,
  parameter int STARVE_LIMIT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           cpu_addr,
  input  logic                  cpu_memread,
  input  logic                  cpu_memwrite,
  input  logic                  dmem_clk_stall,
  output logic [31:0]           mem_addr,
  output logic                  mem_line_read,
  output logic                  mem_line_write,
  output logic [LINE_WIDTH-1:0] mem_line_wdata,
  input  logic [LINE_WIDTH-1:0] mem_line_rdata,
  dmem_line_arbiter_if.slave    req_if,
  output logic                  cpu_hold
);

  arb_state_e                 state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic                       id_q, id_d;
  logic                       wr_q, wr_d;
  logic [LINE_ADDR_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0]      wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]      rdata_q, rdata_d;

  logic [1:0] grant;
  logic       arb_en, accept, grant_id, free, issue;

  // A line op may only use the memory when neither the CPU nor an in-flight access owns it.
  assign free   = !dmem_clk_stall && !cpu_memread && !cpu_memwrite && !reset;
  assign issue  = (state_q == PEND) && free;
  assign arb_en = (state_q == IDLE) && !reset;

  rr_arb2 u_rr_arb2 (
    .valid      (req_if.req_valid),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (grant)
  );

  assign accept   = |grant;
  assign grant_id = grant[1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    wr_d         = wr_q;
    line_d       = line_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d      = PEND;
        last_grant_d = grant_id;
        id_d         = grant_id;
        wr_d         = req_if.req_write[grant_id];
        line_d       = grant_id ? req_if.req_line1  : req_if.req_line0;
        wdata_d      = grant_id ? req_if.req_wdata1 : req_if.req_wdata0;
      end
      PEND: if (free) state_d = wr_q ? DONE : RCAP;
      RCAP: begin
        rdata_d = mem_line_rdata;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the wide data holders are reset as well, so mem_line_wdata/rsp_rdata never expose stale lines.
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      wr_q         <= 1'b0;
      line_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      wr_q         <= wr_d;
      line_q       <= line_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign req_if.req_ready = grant;
  assign req_if.rsp_valid = ((state_q == DONE) && !reset) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign req_if.rsp_rdata = rdata_q;

  assign mem_line_read  = issue && !wr_q;
  assign mem_line_write = issue && wr_q;
  assign mem_addr       = issue ? line_to_byte_addr(32'(line_q)) : cpu_addr;
  assign mem_line_wdata = wdata_q;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             cpu_hold_q, cpu_hold_d;

  // Counter saturates at the limit; hold stays up until the op finally leaves PEND.
  always_comb begin
    wait_cnt_d = '0;
    cpu_hold_d = 1'b0;
    if ((state_q == PEND) && (state_d == PEND)) begin
      wait_cnt_d = (wait_cnt_q == CNT_W'(STARVE_LIMIT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
      cpu_hold_d = cpu_hold_q || (wait_cnt_d == CNT_W'(STARVE_LIMIT));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      cpu_hold_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  assign cpu_hold = cpu_hold_q;
`else
  // Limit only matters when the starvation counter is built.
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign cpu_hold = 1'b0;
`endif

endmodule
